// File: rtl/lfsr_prbs_gen_if.sv
// Interface bundle for lfsr_prbs_gen: control inputs from the consumer side
// (master) and the registered generator outputs (slave = the generator).
interface lfsr_prbs_gen_if #(
   parameter int unsigned WIDTH = 7,
   parameter int unsigned LEN_W = 8
);
   logic             seed_load;
   logic [WIDTH-1:0] seed;
   logic             en;
   logic             start;
   logic [LEN_W-1:0] burst_len;
   logic [WIDTH-1:0] lfsr_out;
   logic             bit_out;
   logic             valid;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] step_cnt;
   logic             period_done;

   modport master (
      output seed_load, seed, en, start, burst_len,
      input  lfsr_out, bit_out, valid, busy, done, step_cnt, period_done
   );

   modport slave (
      input  seed_load, seed, en, start, burst_len,
      output lfsr_out, bit_out, valid, busy, done, step_cnt, period_done
   );
endinterface

// File: rtl/lfsr_prbs_gen.sv
// Parametrised Fibonacci LFSR / PRBS generator with zero-seed guard,
// burst mode (start/len/busy/done) and per-step valid strobe.
// Optional macro LFSR_PRBS_PERIOD_EN enables the step counter and the
// period_done wrap pulse; without it both outputs are tied low.
module lfsr_prbs_gen #(
   parameter int unsigned      WIDTH        = 7,
   parameter logic [WIDTH-1:0] TAPS         = 7'h60,
   parameter logic [WIDTH-1:0] SEED_DEFAULT = 7'h01,
   parameter int unsigned      LEN_W        = 8,
   parameter int unsigned      PERIOD       = 127
) (
   input  logic           clk,
   input  logic           rst,
   lfsr_prbs_gen_if.slave bus
);

   localparam logic [0:0]       ST_IDLE     = 1'b0;
   localparam logic [0:0]       ST_RUN      = 1'b1;
   localparam logic [WIDTH-1:0] ZERO_W      = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE_W       = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [LEN_W-1:0] ZERO_L      = {LEN_W{1'b0}};
   localparam logic [LEN_W-1:0] ONE_L       = {{(LEN_W-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] PERIOD_LAST = WIDTH'(PERIOD - 1);

   // Feedback bit: parity of the tapped state bits.
   function automatic logic lfsr_fb(input logic [WIDTH-1:0] s);
      return ^(s & TAPS);
   endfunction

   logic [WIDTH-1:0] r_state;
   logic [0:0]       r_fsm;
   logic [LEN_W-1:0] r_rem;
   logic             r_valid;
   logic             r_busy;
   logic             r_done;

   logic [WIDTH-1:0] w_state_nxt;
   logic [0:0]       w_fsm_nxt;
   logic [LEN_W-1:0] w_rem_nxt;
   logic             w_step;
   logic             w_done_nxt;

   // Next-state decode: seed_load beats start, start beats a step.
   always_comb begin
      w_state_nxt = r_state;
      w_fsm_nxt   = r_fsm;
      w_rem_nxt   = r_rem;
      w_step      = 1'b0;
      w_done_nxt  = 1'b0;
      if (bus.seed_load) begin
         // A zero seed would lock the LFSR, so substitute the default.
         w_state_nxt = (bus.seed == ZERO_W) ? SEED_DEFAULT : bus.seed;
         w_fsm_nxt   = ST_IDLE;
         w_rem_nxt   = ZERO_L;
      end else begin
         case (r_fsm)
            ST_IDLE: begin
               if (bus.start) begin
                  if (bus.burst_len != ZERO_L) begin
                     w_fsm_nxt = ST_RUN;
                     w_rem_nxt = bus.burst_len;
                  end else begin
                     w_done_nxt = 1'b1;
                  end
               end else if (bus.en) begin
                  w_step = 1'b1;
               end else begin
                  w_step = 1'b0;
               end
            end
            ST_RUN: begin
               if (bus.en) begin
                  w_step    = 1'b1;
                  w_rem_nxt = r_rem - ONE_L;
                  if (r_rem == ONE_L) begin
                     w_fsm_nxt  = ST_IDLE;
                     w_done_nxt = 1'b1;
                  end else begin
                     w_fsm_nxt = ST_RUN;
                  end
               end else begin
                  w_step = 1'b0;
               end
            end
            default: begin
               w_fsm_nxt = ST_IDLE;
               w_rem_nxt = ZERO_L;
            end
         endcase
         if (w_step) begin
            w_state_nxt = {r_state[WIDTH-2:0], lfsr_fb(r_state)};
         end else begin
            w_state_nxt = r_state;
         end
      end
   end

   // State, FSM and registered strobes.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= SEED_DEFAULT;
         r_fsm   <= ST_IDLE;
         r_rem   <= ZERO_L;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_fsm   <= w_fsm_nxt;
         r_rem   <= w_rem_nxt;
         r_valid <= w_step;
         r_busy  <= (w_fsm_nxt == ST_RUN);
         r_done  <= w_done_nxt;
      end
   end

   assign bus.lfsr_out = r_state;
   assign bus.bit_out  = r_state[WIDTH-1];
   assign bus.valid    = r_valid;
   assign bus.busy     = r_busy;
   assign bus.done     = r_done;

`ifdef LFSR_PRBS_PERIOD_EN
   logic [WIDTH-1:0] r_step_cnt;
   logic             r_period_done;

   // Step counter wrapping at PERIOD, pulsing period_done alongside valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_step_cnt    <= ZERO_W;
         r_period_done <= 1'b0;
      end else if (bus.seed_load) begin
         r_step_cnt    <= ZERO_W;
         r_period_done <= 1'b0;
      end else if (w_step) begin
         if (r_step_cnt == PERIOD_LAST) begin
            r_step_cnt    <= ZERO_W;
            r_period_done <= 1'b1;
         end else begin
            r_step_cnt    <= r_step_cnt + ONE_W;
            r_period_done <= 1'b0;
         end
      end else begin
         r_period_done <= 1'b0;
      end
   end

   assign bus.step_cnt    = r_step_cnt;
   assign bus.period_done = r_period_done;
`else
   logic [WIDTH-1:0] w_unused_period;
   assign w_unused_period  = PERIOD_LAST ^ ONE_W;
   assign bus.step_cnt     = ZERO_W;
   assign bus.period_done  = 1'b0;
`endif

endmodule
